// File: rtl/ime_frame_tx.sv
// Frame transmitter: buffers samples in a FIFO and cuts them into frames of frame_len beats
// with flush/filler support and a credit cross-check. Option macro: IME_FRAME_TX_STICKY_POISON_EN.
module ime_frame_tx #(
    parameter int W_ACC      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W_ACC-1:0]              in_sample,
    input  logic [7:0]                    in_tuser,
    input  logic                          in_poison,
    input  logic [15:0]                   frame_len,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W_ACC-1:0]              out_partial_acc,
    output logic [7:0]                    out_tuser,
    output logic                          out_last,
    output logic                          out_poison,
    input  logic [15:0]                   credit_depth,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frame_count,
    output logic                          credit_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OPEN       = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

    logic [W_ACC-1:0]      mem_data_r [FIFO_DEPTH];
    logic [7:0]            mem_tuser_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_poison_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [LW-1:0]         level_r;

    state_t                state_r;
    logic [15:0]           beat_idx_r;
    logic [15:0]           len_lat_r;
    logic                  out_valid_r;
    logic [W_ACC-1:0]      out_data_r;
    logic [7:0]            out_tuser_r;
    logic                  out_last_r;
    logic                  out_poison_r;
    logic [15:0]           out_idx_r;
    logic [15:0]           out_len_r;
    logic                  out_filler_r;
    logic [15:0]           frame_count_r;
    logic                  credit_err_r;
`ifdef IME_FRAME_TX_STICKY_POISON_EN
    logic                  sticky_r;
`endif

    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  slot_free_s;
    logic                  filler_s;
    logic                  load_s;
    logic [15:0]           len_s;
    logic                  last_s;
    logic                  poison_s;
    logic                  out_hs_s;

    // Handshake, load and last-beat decisions for the current cycle.
    always_comb begin
        fifo_empty_s = (level_r == {LW{1'b0}});
        fifo_full_s  = (level_r == FULL_LVL);
        push_s       = in_valid && !fifo_full_s;
        slot_free_s  = !out_valid_r || out_ready;
        filler_s     = (state_r == FLUSH_PEND) && fifo_empty_s;
        load_s       = slot_free_s && (!fifo_empty_s || filler_s);
        pop_s        = load_s && !fifo_empty_s;
        out_hs_s     = out_valid_r && out_ready;
        if (state_r == IDLE) begin
            len_s = (frame_len == 16'd0) ? 16'd1 : frame_len;
        end else begin
            len_s = len_lat_r;
        end
        // A flush coinciding with a load in OPEN turns that beat into the last one.
        last_s = ((beat_idx_r + 16'd1) == len_s) || (state_r == FLUSH_PEND)
                 || ((state_r == OPEN) && flush);
`ifdef IME_FRAME_TX_STICKY_POISON_EN
        poison_s = filler_s ? sticky_r : (mem_poison_r[rd_ptr_r] || sticky_r);
`else
        poison_s = filler_s ? 1'b0 : mem_poison_r[rd_ptr_r];
`endif
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r]   <= in_sample;
            mem_tuser_r[wr_ptr_r]  <= in_tuser;
            mem_poison_r[wr_ptr_r] <= in_poison;
        end else begin
            mem_poison_r <= mem_poison_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Framing FSM and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            beat_idx_r   <= 16'd0;
            len_lat_r    <= 16'd1;
            out_valid_r  <= 1'b0;
            out_data_r   <= {W_ACC{1'b0}};
            out_tuser_r  <= 8'd0;
            out_last_r   <= 1'b0;
            out_poison_r <= 1'b0;
            out_idx_r    <= 16'd0;
            out_len_r    <= 16'd1;
            out_filler_r <= 1'b0;
`ifdef IME_FRAME_TX_STICKY_POISON_EN
            sticky_r     <= 1'b0;
`endif
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= filler_s ? {W_ACC{1'b0}} : mem_data_r[rd_ptr_r];
            out_tuser_r  <= filler_s ? out_tuser_r : mem_tuser_r[rd_ptr_r];
            out_last_r   <= last_s;
            out_poison_r <= poison_s;
            out_idx_r    <= beat_idx_r;
            out_len_r    <= len_s;
            out_filler_r <= filler_s;
            len_lat_r    <= len_s;
`ifdef IME_FRAME_TX_STICKY_POISON_EN
            sticky_r     <= last_s ? 1'b0 : poison_s;
`endif
            if (last_s) begin
                beat_idx_r <= 16'd0;
                state_r    <= IDLE;
            end else begin
                beat_idx_r <= beat_idx_r + 16'd1;
                state_r    <= OPEN;
            end
        end else begin
            if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            if ((state_r == OPEN) && flush) begin
                state_r <= FLUSH_PEND;
            end
        end
    end

    // Completed-frame counter and sticky credit check (filler beats are not checked).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_r <= 16'd0;
            credit_err_r  <= 1'b0;
        end else begin
            if (out_hs_s && out_last_r) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (out_hs_s && !out_filler_r && (credit_depth != (out_len_r - out_idx_r))) begin
                credit_err_r <= 1'b1;
            end
        end
    end

    assign in_ready        = !fifo_full_s;
    assign out_valid       = out_valid_r;
    assign out_partial_acc = out_data_r;
    assign out_tuser       = out_tuser_r;
    assign out_last        = out_last_r;
    assign out_poison      = out_poison_r;
    assign fifo_level      = level_r;
    assign frame_count     = frame_count_r;
    assign credit_err      = credit_err_r;

endmodule

// File: tb/tb_ime_frame_tx.sv
// Directed scoreboard bench for ime_frame_tx; expected beats are queued as stimulus is driven.
module tb_ime_frame_tx;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sample;
    logic [7:0]  in_tuser;
    logic        in_poison;
    logic [15:0] frame_len;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_partial_acc;
    logic [7:0]  out_tuser;
    logic        out_last;
    logic        out_poison;
    logic [15:0] credit_depth;
    logic [2:0]  fifo_level;
    logic [15:0] frame_count;
    logic        credit_err;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tuser;
        logic        last;
        logic        poison;
        logic [15:0] credit;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    ime_frame_tx #(.W_ACC(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .in_tuser(in_tuser), .in_poison(in_poison), .frame_len(frame_len),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_partial_acc(out_partial_acc), .out_tuser(out_tuser),
        .out_last(out_last), .out_poison(out_poison), .credit_depth(credit_depth),
        .fifo_level(fifo_level), .frame_count(frame_count), .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [7:0] u, input logic l,
                               input logic p, input logic [15:0] c);
        beat_t e;
        e.data = d; e.tuser = u; e.last = l; e.poison = p; e.credit = c;
        exp_q.push_back(e);
    endtask

    // One cycle: score any handshake pending at the next edge, then step past that edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat observed=%0h expected=none", out_partial_acc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", out_partial_acc, e.data);
                chk("beat_tuser", {24'd0, out_tuser}, {24'd0, e.tuser});
                chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
                chk("beat_poison", {31'd0, out_poison}, {31'd0, e.poison});
                credit_depth = e.credit;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] u, input logic p);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_sample = d; in_tuser = u; in_poison = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_queue", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sample = 32'd0; in_tuser = 8'd0;
        in_poison = 1'b0; frame_len = 16'd4; flush = 1'b0; out_ready = 1'b0;
        credit_depth = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_partial_acc, 32'd0);
        chk("rst_out_tuser", {24'd0, out_tuser}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_poison", {31'd0, out_poison}, 32'd0);
        chk("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_credit_err", {31'd0, credit_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic framing, frame_len 4, samples 1..8.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            expect_beat(i, 8'(i), (i % 4) == 0, 1'b0, 16'(4 - ((i - 1) % 4)));
        end
        for (int i = 1; i <= 8; i++) begin
            send(i, 8'(i), 1'b0);
        end
        drain();
        chk("basic_frames", {16'd0, frame_count}, 32'd2);
        chk("basic_credit", {31'd0, credit_err}, 32'd0);

        // Zero length: every beat last.
        frame_len = 16'd0;
        for (int i = 0; i < 3; i++) begin
            expect_beat(32'h100 + i, 8'(8'h20 + i), 1'b1, 1'b0, 16'd1);
        end
        for (int i = 0; i < 3; i++) begin
            send(32'h100 + i, 8'(8'h20 + i), 1'b0);
        end
        drain();
        chk("zero_len_frames", {16'd0, frame_count}, 32'd5);

        // Flush with data buffered: third beat becomes last.
        frame_len = 16'd8;
        out_ready = 1'b0;
        expect_beat(32'hA1, 8'h31, 1'b0, 1'b0, 16'd8);
        expect_beat(32'hA2, 8'h32, 1'b0, 1'b0, 16'd7);
        expect_beat(32'hA3, 8'h33, 1'b1, 1'b0, 16'd6);
        send(32'hA1, 8'h31, 1'b0);
        send(32'hA2, 8'h32, 1'b0);
        send(32'hA3, 8'h33, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("flush_data_frames", {16'd0, frame_count}, 32'd6);

        // Flush with empty FIFO: zero filler carrying the previous tuser.
        expect_beat(32'hB4, 8'h44, 1'b0, 1'b0, 16'd8);
        expect_beat(32'hB5, 8'h55, 1'b0, 1'b0, 16'd7);
        send(32'hB4, 8'h44, 1'b0);
        send(32'hB5, 8'h55, 1'b0);
        drain();
        chk("pre_flush_idle", {31'd0, out_valid}, 32'd0);
        expect_beat(32'd0, 8'h55, 1'b1, 1'b0, 16'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain();
        chk("filler_frames", {16'd0, frame_count}, 32'd7);
        chk("filler_credit_skip", {31'd0, credit_err}, 32'd0);

        // Flush while IDLE is ignored.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("idle_flush_ignored", {31'd0, out_valid}, 32'd0);

        // Backpressure: 5 samples, FIFO fills behind the held first beat.
        frame_len = 16'd5;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_beat(32'hC0 + i, 8'(8'hB0 + i), i == 4, 1'b0, 16'(5 - i));
        end
        for (int i = 0; i < 5; i++) begin
            send(32'hC0 + i, 8'(8'hB0 + i), 1'b0);
        end
        repeat (5) tick();
        chk("bp_level", {29'd0, fifo_level}, 32'd4);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_data", out_partial_acc, 32'hC0);
        chk("bp_hold_tuser", {24'd0, out_tuser}, 32'hB0);
        out_ready = 1'b1;
        drain();
        chk("bp_frames", {16'd0, frame_count}, 32'd8);

        // Poison on beat 2 of a 4-beat frame, then a clean single-beat frame.
        frame_len = 16'd4;
`ifdef IME_FRAME_TX_STICKY_POISON_EN
        expect_beat(32'hD1, 8'h61, 1'b0, 1'b0, 16'd4);
        expect_beat(32'hD2, 8'h62, 1'b0, 1'b1, 16'd3);
        expect_beat(32'hD3, 8'h63, 1'b0, 1'b1, 16'd2);
        expect_beat(32'hD4, 8'h64, 1'b1, 1'b1, 16'd1);
`else
        expect_beat(32'hD1, 8'h61, 1'b0, 1'b0, 16'd4);
        expect_beat(32'hD2, 8'h62, 1'b0, 1'b1, 16'd3);
        expect_beat(32'hD3, 8'h63, 1'b0, 1'b0, 16'd2);
        expect_beat(32'hD4, 8'h64, 1'b1, 1'b0, 16'd1);
`endif
        send(32'hD1, 8'h61, 1'b0);
        send(32'hD2, 8'h62, 1'b1);
        send(32'hD3, 8'h63, 1'b0);
        send(32'hD4, 8'h64, 1'b0);
        drain();
        frame_len = 16'd1;
        expect_beat(32'hD5, 8'h65, 1'b1, 1'b0, 16'd1);
        send(32'hD5, 8'h65, 1'b0);
        drain();
        chk("poison_frames", {16'd0, frame_count}, 32'd10);
        chk("pre_mismatch_credit", {31'd0, credit_err}, 32'd0);

        // Credit mismatch on beat 1 latches credit_err.
        frame_len = 16'd4;
        expect_beat(32'hE1, 8'h71, 1'b0, 1'b0, 16'd2);
        expect_beat(32'hE2, 8'h72, 1'b0, 1'b0, 16'd3);
        expect_beat(32'hE3, 8'h73, 1'b0, 1'b0, 16'd2);
        expect_beat(32'hE4, 8'h74, 1'b1, 1'b0, 16'd1);
        for (int i = 1; i <= 4; i++) begin
            send(32'hE0 + i, 8'(8'h70 + i), 1'b0);
        end
        drain();
        chk("credit_err_set", {31'd0, credit_err}, 32'd1);
        repeat (4) tick();
        chk("credit_err_sticky", {31'd0, credit_err}, 32'd1);

        // Reset mid-frame discards everything; next frame relatches frame_len.
        out_ready = 1'b0;
        send(32'hF1, 8'h81, 1'b0);
        send(32'hF2, 8'h82, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("mid_rst_credit_err", {31'd0, credit_err}, 32'd0);
        chk("mid_rst_frames", {16'd0, frame_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        frame_len = 16'd2;
        out_ready = 1'b1;
        expect_beat(32'h91, 8'h91, 1'b0, 1'b0, 16'd2);
        expect_beat(32'h92, 8'h92, 1'b1, 1'b0, 16'd1);
        send(32'h91, 8'h91, 1'b0);
        send(32'h92, 8'h92, 1'b0);
        drain();
        chk("post_rst_frames", {16'd0, frame_count}, 32'd1);
        chk("post_rst_credit", {31'd0, credit_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ime_frame_tx.md
# ime_frame_tx

Frame transmitter feeding the IME accumulation stage's input handshake. Buffers a raw partial-accumulation sample stream in a small FIFO and cuts it into frames of `frame_len` beats. It marks the final beat of each frame with `out_last`, and supports forced frame termination via `flush`, inserting a zero filler beat when no data is buffered. It cross-checks its own beat count against the accumulator's reported `credit_depth` and flags any divergence.

## Interface
- `W_ACC`, 32, sample / partial-accumulation width.
- `FIFO_DEPTH`, 4, input FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: `!fifo_full`.
- `in_sample` in W_ACC: sample value.
- `in_tuser` in 8: per-sample sideband.
- `in_poison` in 1: sample poisoned.
- `frame_len` in 16: beats per frame; 0 treated as 1; latched at the first beat of each frame.
- `flush` in 1: single-cycle request to end the open frame.
- `out_valid` out 1: beat valid toward accumulator.
- `out_ready` in 1: accumulator accepts.
- `out_partial_acc` out W_ACC: beat data.
- `out_tuser` out 8: beat sideband.
- `out_last` out 1: final beat of frame.
- `out_poison` out 1: beat poisoned.
- `credit_depth` in 16: accumulator's remaining-beats report.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: entries held.
- `frame_count` out 16: completed frames, wraps.
- `credit_err` out 1: sticky credit-mismatch flag.

## Operation
- **FIFO write:** on `in_valid && in_ready`, push {sample, tuser, poison}.
- **Output register:**
  - Loads when `!out_valid || out_ready` and either the FIFO is non-empty or a filler is due. Pop happens on the same edge.
  - Holds all fields stable while `out_valid && !out_ready`.
- **Frame latch:** `len_lat = (frame_len==0) ? 1 : frame_len` on each load in IDLE. `beat_idx` counts beats loaded in the current frame.
- **Last marking:** a loaded beat is last if `beat_idx+1 == len_lat` or the state is FLUSH_PEND.
- **FSM states:**
  - IDLE: no beat of the current frame loaded yet. On a load: `last` → stay IDLE, else → OPEN.
  - OPEN: on a last load → IDLE. On `flush` with no load this cycle → FLUSH_PEND.
  - FLUSH_PEND: the next load slot always emits last, then → IDLE. If the FIFO is empty, load filler {data 0, tuser = last emitted tuser, poison 0, last 1}.
- **Flush corner cases:**
  - `flush` in IDLE: ignored.
  - `flush` in FLUSH_PEND: ignored.
  - `flush` in the same cycle as a load in OPEN: that loaded beat becomes last and the FSM → IDLE; no filler.
- **Counters and checks:**
  - `frame_count` increments on `out_valid && out_ready && out_last`.
  - Credit check on each out handshake: expected value = `len_lat - beat_idx_of_beat`. If `credit_depth` differs, set `credit_err`, which stays set until reset. The check is skipped for filler beats.
- **Arithmetic:** `beat_idx` is 16 bit and never exceeds `len_lat-1`. `fifo_level` is exact and counts simultaneous push/pop as net 0. Pointers wrap mod `FIFO_DEPTH`.

## Timing
- **Reset values:** `in_ready=1` (FIFO empty), `out_valid=0`, `out_partial_acc=0`, `out_tuser=0`, `out_last=0`, `out_poison=0`, `fifo_level=0`, `frame_count=0`, `credit_err=0`, FSM=IDLE, `beat_idx=0`.
- **Latency:** a sample pushed at edge t loads the output register at edge t+1 earliest, so `out_valid` is visible after edge t+1.
- **Throughput:** 1 beat/cycle under continuous `out_ready`.
- **Full FIFO:** `in_ready=0`. Push and pop in the same cycle at full is disallowed, because `in_ready` is purely `!full`.
- **Flush with empty FIFO:** the filler loads on the edge after `flush` when the output slot is free.
- **Reset mid-frame:** buffered data and any open frame are discarded; the next frame relatches `frame_len`.

## Configuration
- Macro `IME_FRAME_TX_STICKY_POISON_EN`.
- **Defined:** once any beat of a frame is poisoned, all later beats of that frame (including filler) carry `out_poison=1`. The sticky state clears on the last beat.
- **Undefined:** `out_poison` is the per-beat `in_poison`, and filler carries 0.

## Test plan
- **Basic framing:** `frame_len=4`, 8 samples 1..8, `out_ready=1`, `credit_depth` modelled as 4,3,2,1 → `out_last` on beats 4 and 8, `frame_count=2`, `credit_err=0`.
- **Zero length:** `frame_len=0`, 3 samples → every beat last, `frame_count=3`.
- **Flush with data:** `frame_len=8`, 3 samples, `flush` after beat 2 loads → beat 3 last. With FIFO empty after beat 2 → filler data 0, last 1, tuser = beat 2's tuser.
- **Backpressure:** `FIFO_DEPTH=4`, `out_ready=0` for 10 cycles with continuous input → `fifo_level` reaches 4, `in_ready=0`. The output holds beat 1 stable. Release → 5 beats drain in order.
- **Credit mismatch:** `frame_len=4`, `credit_depth` forced to 2 on beat 1 → `credit_err=1` and stays 1 until `rst_n` low.
- **Sticky poison (macro on):** `frame_len=4`, poison on beat 2 → beats 2-4 poisoned, next frame's beat 1 clean. Macro off → only beat 2 poisoned.
